// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-seeds from the incoming stream, locks after a clean run,
// then counts bit errors against a free-running local LFSR. Optional macro PRBS_CHK_BITCNT_EN adds bit_count.
module prbs_checker #(
  parameter int PRBS_ORDER  = 7,
  parameter int LOCK_CNT    = 64,
  parameter int WIN_BITS    = 1024,
  parameter int LOSS_THRESH = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             serial_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             lock_loss
);

  localparam int TAP_A   = PRBS_ORDER;
  localparam int TAP_B   = (PRBS_ORDER == 7)  ? 6  :
                           (PRBS_ORDER == 15) ? 14 :
                           (PRBS_ORDER == 23) ? 18 : 28;
  localparam int SEED_W  = $clog2(PRBS_ORDER + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_BITS + 1);
  localparam int TALLY_W = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_t;

  state_t                state_reg, state_next;
  logic [PRBS_ORDER-1:0] h_reg, h_next;
  logic [SEED_W-1:0]     seed_cnt_reg, seed_cnt_next;
  logic [MATCH_W-1:0]    match_cnt_reg, match_cnt_next;
  logic [WIN_W-1:0]      win_cnt_reg, win_cnt_next;
  logic [TALLY_W-1:0]    tally_reg, tally_next;
  logic                  err_pulse_reg, err_pulse_next;
  logic                  lock_loss_reg, lock_loss_next;
  logic                  locked_reg, locked_next;
  logic [CNT_W-1:0]      err_count_reg;

  logic                  expected_bit;
  logic                  bit_err;
  logic [PRBS_ORDER-1:0] h_shift;
  logic                  seed_done;
  logic                  lock_hit;
  logic                  loss_hit;
  logic                  win_end;

  assign expected_bit = h_reg[TAP_A-1] ^ h_reg[TAP_B-1];
  assign bit_err      = serial_in ^ expected_bit;
  assign h_shift      = {h_reg[PRBS_ORDER-2:0], serial_in};
  assign seed_done    = (seed_cnt_reg == SEED_W'(PRBS_ORDER - 1));
  assign lock_hit     = !bit_err && (match_cnt_reg == MATCH_W'(LOCK_CNT - 1));
  // Tally never reaches the threshold while locked, so one more error is the trigger.
  assign loss_hit     = bit_err && (tally_reg == TALLY_W'(LOSS_THRESH - 1));
  assign win_end      = (win_cnt_reg == WIN_W'(WIN_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (in_valid) begin
      case (state_reg)
        SEED:    if (seed_done && (h_shift != '0)) state_next = CHECK;
        CHECK:   if (lock_hit) state_next = LOCKED;
        LOCKED:  if (loss_hit) state_next = SEED;
        default: state_next = SEED;
      endcase
    end
  end

  always_comb begin
    err_pulse_next = in_valid && (state_reg == LOCKED) && bit_err;
    lock_loss_next = in_valid && (state_reg == LOCKED) && loss_hit;
    locked_next    = (state_next == LOCKED);
  end

  always_comb begin
    h_next         = h_reg;
    seed_cnt_next  = seed_cnt_reg;
    match_cnt_next = match_cnt_reg;
    win_cnt_next   = win_cnt_reg;
    tally_next     = tally_reg;
    if (in_valid) begin
      case (state_reg)
        SEED: begin
          h_next         = h_shift;
          seed_cnt_next  = seed_done ? '0 : seed_cnt_reg + SEED_W'(1);
          match_cnt_next = '0;
        end
        CHECK: begin
          h_next         = h_shift;
          match_cnt_next = bit_err ? '0 : match_cnt_reg + MATCH_W'(1);
          win_cnt_next   = '0;
          tally_next     = '0;
        end
        LOCKED: begin
          if (loss_hit) begin
            h_next        = '0;
            seed_cnt_next = '0;
            win_cnt_next  = '0;
            tally_next    = '0;
          end else begin
            // Free-run on our own prediction so a channel error is seen exactly once.
            h_next = {h_reg[PRBS_ORDER-2:0], expected_bit};
            if (win_end) begin
              win_cnt_next = '0;
              tally_next   = '0;
            end else begin
              win_cnt_next = win_cnt_reg + WIN_W'(1);
              tally_next   = tally_reg + TALLY_W'(bit_err);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg         <= '0;
      seed_cnt_reg  <= '0;
      match_cnt_reg <= '0;
      win_cnt_reg   <= '0;
      tally_reg     <= '0;
      err_pulse_reg <= 1'b0;
      lock_loss_reg <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      h_reg         <= h_next;
      seed_cnt_reg  <= seed_cnt_next;
      match_cnt_reg <= match_cnt_next;
      win_cnt_reg   <= win_cnt_next;
      tally_reg     <= tally_next;
      err_pulse_reg <= err_pulse_next;
      lock_loss_reg <= lock_loss_next;
      locked_reg    <= locked_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= '0;
    end else if (clear_cnt) begin
      err_count_reg <= '0;
    end else if (err_pulse_next && (err_count_reg != '1)) begin
      err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count_reg <= '0;
    end else if (clear_cnt) begin
      bit_count_reg <= '0;
    end else if (in_valid && (state_reg == LOCKED) && (bit_count_reg != '1)) begin
      bit_count_reg <= bit_count_reg + CNT_W'(1);
    end
  end

  assign bit_count = bit_count_reg;
`else
  assign bit_count = '0;
`endif

  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign lock_loss = lock_loss_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a PRBS7 and a PRBS15 instance fed from local generators.
module tb_prbs_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v7, s7, c7, v15, s15, c15;
  logic        lk7, ep7, ll7, lk15, ep15, ll15;
  logic [31:0] ec7, bc7, ec15, bc15;

  prbs_checker #(.PRBS_ORDER(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(v7), .serial_in(s7), .clear_cnt(c7),
    .locked(lk7), .err_pulse(ep7), .err_count(ec7), .bit_count(bc7), .lock_loss(ll7)
  );

  prbs_checker #(.PRBS_ORDER(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .in_valid(v15), .serial_in(s15), .clear_cnt(c15),
    .locked(lk15), .err_pulse(ep15), .err_count(ec15), .bit_count(bc15), .lock_loss(ll15)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0]  g7  = 7'h01;
  logic [14:0] g15 = 15'h0001;
  int          lb7 = 0;
  bit          on7 = 1'b0;

`ifdef PRBS_CHK_BITCNT_EN
  localparam bit BITCNT = 1'b1;
`else
  localparam bit BITCNT = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step7(input bit v, input bit b, input bit clr);
    @(negedge clk);
    v7 = v; s7 = b; c7 = clr;
    v15 = 1'b0; s15 = 1'b0; c15 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step15(input bit b);
    @(negedge clk);
    v15 = 1'b1; s15 = b; c15 = 1'b0;
    v7 = 1'b0; s7 = 1'b0; c7 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send7(input bit flip, input bit clr);
    bit b;
    b  = g7[6] ^ g7[5];
    g7 = {g7[5:0], b};
    step7(1'b1, b ^ flip, clr);
    if (on7) lb7++;
  endtask

  task automatic send15(input bit flip);
    bit b;
    b   = g15[14] ^ g15[13];
    g15 = {g15[13:0], b};
    step15(b ^ flip);
  endtask

  initial begin
    int pulses, drops, losses;
    rst_n = 1'b0;
    v7 = 0; s7 = 0; c7 = 0; v15 = 0; s15 = 0; c15 = 0;
    repeat (3) @(negedge clk);
    check_val("reset_locked", lk7, 0);
    check_val("reset_err_pulse", ep7, 0);
    check_val("reset_err_count", ec7, 0);
    check_val("reset_bit_count", bc7, 0);
    check_val("reset_lock_loss", ll7, 0);
    rst_n = 1'b1;

    // Clean PRBS7: lock appears right after bit 71.
    for (int i = 1; i <= 70; i++) send7(0, 0);
    check_val("p7_not_locked_at_70", lk7, 0);
    send7(0, 0);
    check_val("p7_locked_at_71", lk7, 1);
    on7 = 1'b1;
    pulses = 0; drops = 0;
    for (int i = 72; i <= 10000; i++) begin
      send7(0, 0);
      if (ep7) pulses++;
      if (!lk7) drops++;
    end
    check_val("p7_clean_pulses", pulses, 0);
    check_val("p7_clean_drops", drops, 0);
    check_val("p7_clean_err_count", ec7, 0);
    check_val("p7_bit_count", bc7, BITCNT ? 9929 : 0);

    // Single flipped bit.
    for (int i = 0; i < 499; i++) send7(0, 0);
    send7(1, 0);
    check_val("single_err_pulse", ep7, 1);
    check_val("single_err_count", ec7, 1);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      send7(0, 0);
      if (ep7) pulses++;
    end
    check_val("single_no_extra_pulse", pulses, 0);
    check_val("single_still_locked", lk7, 1);

    // in_valid gaps with garbage data on the line.
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 0) step7(0, 1'($urandom_range(0, 1)), 0);
      else send7(0, 0);
      if (ep7) pulses++;
    end
    check_val("gap_pulses", pulses, 0);
    check_val("gap_err_count", ec7, 1);

    // Clear, then 15 errors per window for 5 windows aligned to the DUT window.
    send7(0, 1);
    check_val("clear_err_count", ec7, 0);
    while (lb7 % 1024 != 0) send7(0, 0);
    pulses = 0; drops = 0; losses = 0;
    for (int w = 0; w < 5; w++) begin
      for (int p = 0; p < 1024; p++) begin
        send7((p < 150) && (p % 10 == 0), 0);
        if (ep7) pulses++;
        if (!lk7) drops++;
        if (ll7) losses++;
      end
    end
    check_val("win15_pulses", pulses, 75);
    check_val("win15_err_count", ec7, 75);
    check_val("win15_drops", drops, 0);
    check_val("win15_losses", losses, 0);

    // clear_cnt on the same cycle as an error.
    send7(1, 1);
    check_val("clr_err_pulse", ep7, 1);
    check_val("clr_err_count", ec7, 0);
    check_val("clr_bit_count", bc7, 0);
    send7(1, 0);
    check_val("post_clr_err_count", ec7, 1);

    // PRBS15: lock, 16 errors in one window, loss, relock.
    for (int i = 1; i <= 78; i++) send15(0);
    check_val("p15_not_locked_at_78", lk15, 0);
    send15(0);
    check_val("p15_locked_at_79", lk15, 1);
    losses = 0;
    for (int i = 1; i <= 150; i++) begin
      send15(i % 10 == 0);
      if (ll15) losses++;
    end
    check_val("p15_locked_after_15", lk15, 1);
    check_val("p15_no_early_loss", losses, 0);
    for (int i = 151; i <= 160; i++) send15(i % 10 == 0);
    check_val("p15_lock_loss_pulse", ll15, 1);
    check_val("p15_unlocked", lk15, 0);
    check_val("p15_err_count_16", ec15, 16);
    send15(0);
    check_val("p15_lock_loss_one_cycle", ll15, 0);
    for (int i = 2; i <= 78; i++) send15(0);
    check_val("p15_relock_not_yet", lk15, 0);
    send15(0);
    check_val("p15_relocked", lk15, 1);
    check_val("p15_err_count_retained", ec15, 16);

    // Asynchronous reset mid-lock.
    send7(1, 0);
    check_val("pre_reset_err_pulse", ep7, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_locked7", lk7, 0);
    check_val("async_rst_err_pulse7", ep7, 0);
    check_val("async_rst_err_count7", ec7, 0);
    check_val("async_rst_locked15", lk15, 0);
    check_val("async_rst_err_count15", ec15, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero stream never seeds.
    pulses = 0; drops = 0;
    for (int i = 0; i < 200; i++) begin
      step7(1, 0, 0);
      if (lk7) drops++;
      if (ep7) pulses++;
    end
    check_val("zeros_never_locked", drops, 0);
    check_val("zeros_no_pulses", pulses, 0);
    check_val("zeros_err_count", ec7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial PRBS checker that sits directly downstream of the PHY BER channel injector.
- Self-synchronizes to an incoming PRBS stream, declares lock, then counts bit errors against a free-running local LFSR.
- Error pulse and counters feed the UVM scoreboard and coverage, which cross-check them against the injector's error_injected flags.
- The lock/loss-of-lock FSM lets stress tests measure recovery after error bursts.

Parameters:
- PRBS_ORDER, 7, polynomial select. Legal values: 7 (x^7+x^6+1), 15 (x^15+x^14+1), 23 (x^23+x^18+1), 31 (x^31+x^28+1).
- LOCK_CNT, 64, consecutive error-free bits required in CHECK before declaring lock.
- WIN_BITS, 1024, length of the loss-of-lock window in valid bits.
- LOSS_THRESH, 16, errors within one window that force loss of lock.
- CNT_W, 32, width of the error and bit counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  serial_in is sampled only when high
- serial_in  in  1  received serial bit
- clear_cnt  in  1  synchronous clear of err_count and bit_count
- locked  out  1  checker is in LOCKED
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED
- err_count  out  CNT_W  saturating error count while LOCKED
- bit_count  out  CNT_W  saturating count of bits checked while LOCKED (see Optional Feature)
- lock_loss  out  1  one-cycle pulse on the LOCKED->SEED transition

Behaviour:
- Reset: state=SEED, history h=0, seed/match/window counters=0, all outputs 0.
- History register h[PRBS_ORDER-1:0], h[0] = newest bit.
- expected = h[TA-1]^h[TB-1], with (TA,TB) = (7,6), (15,14), (23,18), (31,28).
- No state or counter changes on cycles with in_valid=0.
- SEED:
  - Each valid bit shifts serial_in into h; seed counter increments.
  - After PRBS_ORDER bits: if h != 0, go to CHECK; if h == 0 (all-zero stream), restart the seed count and stay in SEED.
- CHECK:
  - Each valid bit compares serial_in with expected, then shifts serial_in into h.
  - Match: increment match count. Mismatch: clear match count and stay in CHECK.
  - match count reaching LOCK_CNT: go to LOCKED; locked=1 on the following cycle.
- LOCKED:
  - h shifts in expected, not serial_in, so the LFSR free-runs and one channel error is counted exactly once.
  - Mismatch: err_pulse=1 on the cycle after the sampled bit; err_count += 1, saturating at 2^CNT_W-1.
  - Window counter counts valid bits, with a per-window error tally.
  - Tally reaching LOSS_THRESH in the window: go to SEED on the same update; lock_loss pulses and locked=0 on the next cycle. h and the seed counter are cleared.
  - Window counter reaching WIN_BITS without loss: tally and window reset.
  - err_count and bit_count are held (not cleared) on loss of lock.
- Latency: err_pulse, locked and lock_loss are all registered, appearing 1 clk after the triggering sampled bit.
- clear_cnt:
  - Zeroes err_count and bit_count next cycle.
  - An error on the same cycle still pulses err_pulse but is not added (clear wins).
  - Does not affect state, h or the window.
- Reset mid-operation returns immediately to SEED with all outputs 0.

Optional Feature:
- Macro PRBS_CHK_BITCNT_EN.
- Defined: bit_count increments (saturating) on every valid bit while LOCKED, so software can compute BER as err_count/bit_count.
- Undefined: counter logic is omitted and bit_count is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Clean PRBS7, in_valid=1 continuously -> locked=1 at bit 7+64=71 (+1 clk); err_count stays 0 over 10000 bits; with macro, bit_count equals bits since lock.
- Locked PRBS7, single flipped bit at bit 500 -> exactly one err_pulse, 1 clk after that bit; err_count=1; locked stays 1.
- Locked PRBS15, 16 flips within 1024 bits -> lock_loss pulse, locked=0; relock after 15+64 clean bits; err_count=16 retained.
- Locked, 15 flips per window over 5 windows -> never loses lock; err_count=75.
- All-zero input for 200 bits -> stays in SEED; locked=0, err_count=0.
- clear_cnt asserted on the same cycle as an error -> err_pulse=1, err_count=0 next cycle. Also: in_valid=0 gaps mid-stream cause no errors. Also: rst_n low mid-lock -> all outputs 0 asynchronously.
